// File: rtl/uart_frame_parser_pkg.sv
// Shared constants, state encodings and CRC-8 helper for the UART frame parser.
package uart_frame_parser_pkg;

  localparam logic [7:0]  HEADER_BYTE = 8'hA5;
  localparam logic [7:0]  CRC8_POLY   = 8'h07;
  localparam logic [7:0]  CRC8_INIT   = 8'h00;
  localparam int unsigned NUM_OUT     = 11;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PAYLOAD = 2'd1;
  localparam logic [1:0] ST_CHECK   = 2'd2;

  // CRC-8 (MSB first, no reflection, no final XOR) folded over one byte.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/uart_frame_parser_crc8_byte.sv
// Combinational next-CRC from the running CRC and one data byte.
module crc8_byte
  import uart_frame_parser_pkg::*;
(
  input  logic [7:0] i_crc,
  input  logic [7:0] i_data,
  output logic [7:0] o_crc_c
);

  // Single-byte CRC fold.
  always_comb begin
    o_crc_c = crc8_update(i_crc, i_data);
  end

endmodule

// File: rtl/uart_frame_parser.sv
// Parses header / payload / CRC-8 frames from a byte-strobe UART receiver.
module uart_frame_parser
  import uart_frame_parser_pkg::*;
#(
  parameter int unsigned _PAYLOAD_LEN = 11,
  parameter logic [7:0]  _HEADER      = HEADER_BYTE,
  parameter int unsigned _TIMEOUT_CYC = 50000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] uart_data,
  input  logic       uart_done,
  output logic [7:0] rev_data0,
  output logic [7:0] rev_data1,
  output logic [7:0] rev_data2,
  output logic [7:0] rev_data3,
  output logic [7:0] rev_data4,
  output logic [7:0] rev_data5,
  output logic [7:0] rev_data6,
  output logic [7:0] rev_data7,
  output logic [7:0] rev_data8,
  output logic [7:0] rev_data9,
  output logic [7:0] rev_data10,
  output logic       pack_done,
  output logic       crc_err,
  output logic       timeout_err,
  output logic       busy,
  output logic [7:0] frame_cnt,
  output logic [7:0] err_cnt
);

  localparam int unsigned IDX_W = 8;
  localparam int unsigned GAP_W = $clog2(_TIMEOUT_CYC + 1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_crc;
  logic [7:0]       w_crc_nxt;
  logic [GAP_W-1:0] r_gap;
  logic [7:0]       r_shadow [NUM_OUT];
  logic [7:0]       r_rev    [NUM_OUT];
  logic             r_pack_done;
  logic             r_crc_err;
  logic             r_timeout_err;
  logic             r_busy;
  logic [7:0]       r_frame_cnt;
  logic [7:0]       r_err_cnt;
  logic             w_start;
  logic             w_store;
  logic             w_accept;
  logic             w_reject;
  logic             w_timeout;
  logic             w_gap_hit;

  crc8_byte u_crc8_byte (
    .i_crc   (r_crc),
    .i_data  (uart_data),
    .o_crc_c (w_crc_nxt)
  );

  assign w_gap_hit = (r_gap == GAP_W'(_TIMEOUT_CYC - 1));

  // Next-state and per-cycle event decode; a byte strobe always beats the timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_store     = 1'b0;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (uart_done && (uart_data == _HEADER)) begin
          w_start     = 1'b1;
          w_state_nxt = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (uart_done) begin
          w_store = 1'b1;
          if (r_idx == IDX_W'(_PAYLOAD_LEN - 1)) begin
            w_state_nxt = ST_CHECK;
          end
        end else if (w_gap_hit) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (uart_done) begin
          w_state_nxt = ST_IDLE;
          if (uart_data == r_crc) begin
            w_accept = 1'b1;
          end else begin
            w_reject = 1'b1;
          end
        end else if (w_gap_hit) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Frame datapath: index, running CRC, gap counter, shadow and published payload.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_idx <= '0;
      r_crc <= CRC8_INIT;
      r_gap <= '0;
      for (int k = 0; k < NUM_OUT; k++) begin
        r_shadow[k] <= '0;
        r_rev[k]    <= '0;
      end
    end else begin
      if (w_start) begin
        r_idx <= '0;
        r_crc <= CRC8_INIT;
      end else if (w_store) begin
        r_idx <= r_idx + IDX_W'(1);
        r_crc <= w_crc_nxt;
      end
      if (uart_done || (w_state_nxt == ST_IDLE)) begin
        r_gap <= '0;
      end else begin
        r_gap <= r_gap + GAP_W'(1);
      end
      for (int k = 0; k < NUM_OUT; k++) begin
        if (w_store && (r_idx == IDX_W'(k))) begin
          r_shadow[k] <= uart_data;
        end
      end
      if (w_accept) begin
        r_rev <= r_shadow;
      end
    end
  end

  // Status pulses, busy flag and frame/error counters.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_pack_done   <= 1'b0;
      r_crc_err     <= 1'b0;
      r_timeout_err <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_cnt   <= '0;
      r_err_cnt     <= '0;
    end else begin
      r_pack_done   <= w_accept;
      r_crc_err     <= w_reject;
      r_timeout_err <= w_timeout;
      r_busy        <= (w_state_nxt != ST_IDLE);
      if (w_accept) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
      if ((w_reject || w_timeout) && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign rev_data0   = r_rev[0];
  assign rev_data1   = r_rev[1];
  assign rev_data2   = r_rev[2];
  assign rev_data3   = r_rev[3];
  assign rev_data4   = r_rev[4];
  assign rev_data5   = r_rev[5];
  assign rev_data6   = r_rev[6];
  assign rev_data7   = r_rev[7];
  assign rev_data8   = r_rev[8];
  assign rev_data9   = r_rev[9];
  assign rev_data10  = r_rev[10];
  assign pack_done   = r_pack_done;
  assign crc_err     = r_crc_err;
  assign timeout_err = r_timeout_err;
  assign busy        = r_busy;
  assign frame_cnt   = r_frame_cnt;
  assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: a frame-level reference model predicts
// every status pulse, a monitor checks what the DUT presents.
module tb_uart_frame_parser;

  localparam int unsigned PLEN = 11;
  localparam int unsigned TOUT = 50000;
  localparam logic [7:0]  HDR  = 8'hA5;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [7:0] uart_data = 8'h00;
  logic       uart_done = 1'b0;
  logic [7:0] rev_data0, rev_data1, rev_data2, rev_data3, rev_data4, rev_data5;
  logic [7:0] rev_data6, rev_data7, rev_data8, rev_data9, rev_data10;
  logic       pack_done, crc_err, timeout_err, busy;
  logic [7:0] frame_cnt, err_cnt;

  uart_frame_parser #(
    ._PAYLOAD_LEN (PLEN),
    ._HEADER      (HDR),
    ._TIMEOUT_CYC (TOUT)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .uart_data   (uart_data),
    .uart_done   (uart_done),
    .rev_data0   (rev_data0),
    .rev_data1   (rev_data1),
    .rev_data2   (rev_data2),
    .rev_data3   (rev_data3),
    .rev_data4   (rev_data4),
    .rev_data5   (rev_data5),
    .rev_data6   (rev_data6),
    .rev_data7   (rev_data7),
    .rev_data8   (rev_data8),
    .rev_data9   (rev_data9),
    .rev_data10  (rev_data10),
    .pack_done   (pack_done),
    .crc_err     (crc_err),
    .timeout_err (timeout_err),
    .busy        (busy),
    .frame_cnt   (frame_cnt),
    .err_cnt     (err_cnt)
  );

  always #10 sys_clk = ~sys_clk;

  // kind: 0 = pack_done, 1 = crc_err, 2 = timeout_err
  typedef struct {
    int          kind;
    int          cyc;
    logic [7:0]  fcnt;
    logic [7:0]  ecnt;
    logic [87:0] data;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  bit          m_in   = 1'b0;
  int          m_n    = 0;
  int          m_idle = 0;
  logic [87:0] m_pay  = '0;
  logic [87:0] m_last = '0;
  logic [7:0]  m_fcnt = '0;
  logic [7:0]  m_ecnt = '0;

  // CRC-8 poly 0x07 as bit-serial long division of the whole payload, first byte MSB.
  function automatic logic [7:0] ref_crc(input logic [87:0] p);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = 87; i >= 0; i--) begin
      fb = c[7] ^ p[i];
      c  = {c[6:0], 1'b0};
      if (fb) c = c ^ 8'h07;
    end
    return c;
  endfunction

  // Reference model: follows the frame rules on the input strobes and predicts pulses.
  always @(posedge sys_clk) begin : model
    exp_t e;
    if (sys_rst) begin
      m_in = 1'b0; m_n = 0; m_idle = 0;
      m_fcnt = '0; m_ecnt = '0; m_last = '0;
    end else if (uart_done) begin
      m_idle = 0;
      if (!m_in) begin
        if (uart_data == HDR) begin
          m_in = 1'b1; m_n = 0; m_pay = '0;
        end
      end else if (m_n < PLEN) begin
        m_pay = {m_pay[79:0], uart_data};
        m_n++;
      end else begin
        m_in = 1'b0;
        if (uart_data == ref_crc(m_pay)) begin
          m_fcnt = m_fcnt + 8'd1;
          m_last = m_pay;
          e.kind = 0;
        end else begin
          if (m_ecnt != 8'hFF) m_ecnt = m_ecnt + 8'd1;
          e.kind = 1;
        end
        e.cyc = cyc + 1; e.fcnt = m_fcnt; e.ecnt = m_ecnt; e.data = m_last;
        sb.push_back(e);
      end
    end else if (m_in) begin
      m_idle++;
      if (m_idle == TOUT) begin
        m_in = 1'b0; m_idle = 0;
        if (m_ecnt != 8'hFF) m_ecnt = m_ecnt + 8'd1;
        e.kind = 2; e.cyc = cyc + 1; e.fcnt = m_fcnt; e.ecnt = m_ecnt; e.data = m_last;
        sb.push_back(e);
      end
    end
    cyc++;
  end

  // Monitor: checks busy every cycle and matches each status pulse to the scoreboard.
  always @(negedge sys_clk) begin : monitor
    exp_t        e;
    int          kind_got;
    int          npulse;
    logic [87:0] rev;
    rev = {rev_data0, rev_data1, rev_data2, rev_data3, rev_data4, rev_data5,
           rev_data6, rev_data7, rev_data8, rev_data9, rev_data10};
    tests++;
    if (busy !== m_in) begin
      fails++;
      $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, m_in);
    end
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      tests++; fails++;
      $display("FAIL missing_pulse cyc=%0d expected kind=%0d at cyc=%0d", cyc, sb[0].kind, sb[0].cyc);
      void'(sb.pop_front());
    end
    npulse = int'(pack_done === 1'b1) + int'(crc_err === 1'b1) + int'(timeout_err === 1'b1);
    if (npulse > 0) begin
      tests++;
      if (npulse > 1) begin
        fails++;
        $display("FAIL pulse_exclusive cyc=%0d pack=%b crc=%b tmo=%b", cyc, pack_done, crc_err, timeout_err);
        if (sb.size() > 0) void'(sb.pop_front());
      end else if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse cyc=%0d pack=%b crc=%b tmo=%b", cyc, pack_done, crc_err, timeout_err);
      end else begin
        e = sb.pop_front();
        kind_got = pack_done ? 0 : (crc_err ? 1 : 2);
        if (kind_got != e.kind || e.cyc != cyc || frame_cnt !== e.fcnt ||
            err_cnt !== e.ecnt || rev !== e.data) begin
          fails++;
          $display("FAIL event cyc=%0d got kind=%0d fcnt=%0d ecnt=%0d data=%h exp kind=%0d cyc=%0d fcnt=%0d ecnt=%0d data=%h",
                   cyc, kind_got, frame_cnt, err_cnt, rev, e.kind, e.cyc, e.fcnt, e.ecnt, e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // Called at a falling edge; presents one strobe then waits gap idle cycles.
  task automatic send_byte(input logic [7:0] b, input int gap);
    uart_data = b;
    uart_done = 1'b1;
    @(negedge sys_clk);
    uart_done = 1'b0;
    uart_data = 8'($urandom);
    repeat (gap) @(negedge sys_clk);
  endtask

  task automatic send_frame(input logic [87:0] p, input bit bad, input int gmax, input int nbytes);
    logic [7:0] c;
    send_byte(HDR, $urandom_range(0, gmax));
    for (int i = 0; i < nbytes; i++) send_byte(p[87-8*i -: 8], $urandom_range(0, gmax));
    if (nbytes == PLEN) begin
      c = ref_crc(p) ^ (bad ? 8'h01 : 8'h00);
      send_byte(c, $urandom_range(0, gmax));
    end
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    uart_done = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
  endtask

  initial begin : watchdog
    #(20 * 90000);
    $display("FAIL watchdog cycle budget exhausted");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [87:0] p;
    logic [7:0]  g;
    do_reset();
    chk("rst_frame_cnt", frame_cnt, 8'h00);
    chk("rst_err_cnt", err_cnt, 8'h00);
    chk("rst_rev0", rev_data0, 8'h00);
    chk("rst_rev10", rev_data10, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);

    // Known frame 01..0B.
    p = 88'h01_02_03_04_05_06_07_08_09_0A_0B;
    send_frame(p, 1'b0, 0, PLEN);
    idle(2);
    chk("good_rev0", rev_data0, 8'h01);
    chk("good_rev10", rev_data10, 8'h0B);
    chk("good_frame_cnt", frame_cnt, 8'h01);

    // Same frame with a corrupted CRC byte.
    send_frame(p, 1'b1, 1, PLEN);
    idle(2);
    chk("badcrc_err_cnt", err_cnt, 8'h01);
    chk("badcrc_rev0_hold", rev_data0, 8'h01);

    // Inter-byte timeout after 5 payload bytes, then a valid frame.
    send_frame(88'hDEADBEEF01_000000000000, 1'b0, 0, 5);
    idle(TOUT + 10);
    chk("tmo_err_cnt", err_cnt, 8'h02);
    send_frame(88'h10_20_30_40_50_60_70_80_90_A0_B0, 1'b0, 2, PLEN);
    idle(2);
    chk("tmo_after_frame_cnt", frame_cnt, 8'h02);

    // Garbage before header, header values inside payload.
    send_byte(8'h00, 0); send_byte(8'hFF, 1); send_byte(8'h3C, 0);
    send_frame(88'hA5_02_03_A5_05_06_07_08_09_0A_A5, 1'b0, 1, PLEN);
    idle(2);
    chk("a5data_rev0", rev_data0, 8'hA5);
    chk("a5data_rev3", rev_data3, 8'hA5);

    // Reset mid-frame, then a full valid frame.
    send_frame(88'h11_22_33_44_55_66_00_00_00_00_00, 1'b0, 0, 6);
    do_reset();
    chk("midrst_frame_cnt", frame_cnt, 8'h00);
    chk("midrst_err_cnt", err_cnt, 8'h00);
    send_frame(88'h0F_0E_0D_0C_0B_0A_09_08_07_06_05, 1'b0, 1, PLEN);
    idle(2);
    chk("midrst_frame_cnt1", frame_cnt, 8'h01);

    // Randomized frames with garbage, gaps and occasional CRC corruption.
    for (int f = 0; f < 40; f++) begin
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        g = 8'($urandom);
        if (g == HDR) g = 8'h00;
        send_byte(g, $urandom_range(0, 2));
      end
      p = 88'({$urandom, $urandom, $urandom});
      send_frame(p, ($urandom_range(0, 3) == 0), 3, PLEN);
    end
    idle(3);

    // Frame counter wrap with zero-gap frames.
    do_reset();
    for (int f = 0; f < 256; f++) begin
      p = 88'({$urandom, $urandom, $urandom});
      send_frame(p, 1'b0, 0, PLEN);
    end
    idle(2);
    chk("wrap_frame_cnt", frame_cnt, 8'h00);

    // Error counter saturation.
    for (int f = 0; f < 300; f++) begin
      p = 88'({$urandom, $urandom, $urandom});
      send_frame(p, 1'b1, 0, PLEN);
    end
    idle(2);
    chk("sat_err_cnt", err_cnt, 8'hFF);

    idle(5);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got=%0d pending exp=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_frame_parser.md
UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

Interface
REQ-001 Parameter _PAYLOAD_LEN, default 11: number of payload bytes per frame, delivered on rev_data0..rev_data10.
REQ-002 Parameter _HEADER, default 8'hA5: frame start byte.
REQ-003 Parameter _TIMEOUT_CYC, default 50000: maximum idle gap between bytes inside a frame, in sys_clk cycles (1 ms at 50 MHz).
REQ-004 sys_clk  input  1  single clock, 50 MHz domain of the UART receiver.
REQ-005 sys_rst  input  1  synchronous, active-high reset.
REQ-006 uart_data  input  8  received byte, valid when uart_done=1.
REQ-007 uart_done  input  1  one-cycle strobe, one per received byte.
REQ-008 rev_data0..rev_data10  output  8 each  last accepted frame payload; rev_data0 is the function byte.
REQ-009 pack_done  output  1  one-cycle pulse: new valid frame on rev_data*.
REQ-010 crc_err  output  1  one-cycle pulse: frame discarded on CRC mismatch.
REQ-011 timeout_err  output  1  one-cycle pulse: frame aborted on inter-byte timeout.
REQ-012 busy  output  1  high while state is not IDLE.
REQ-013 frame_cnt  output  8  count of accepted frames, wraps 255->0.
REQ-014 err_cnt  output  8  count of CRC and timeout errors, saturates at 255.

Function
REQ-015 Frame format: _HEADER, then _PAYLOAD_LEN payload bytes, then 1 CRC byte; CRC-8, poly 0x07, init 0x00, no reflection, no final XOR, computed over payload bytes only.
REQ-016 States: IDLE, PAYLOAD, CHECK; transitions evaluated only on uart_done, except timeout.
REQ-017 IDLE: byte equal to _HEADER -> PAYLOAD, byte index cleared, running CRC set to 0x00; any other byte is ignored.
REQ-018 PAYLOAD: each byte is written to shadow buffer[index] and folded into the running CRC; index increments; after byte _PAYLOAD_LEN-1 -> CHECK.
REQ-019 A byte equal to _HEADER received in PAYLOAD or CHECK is treated as data, not as a resync.
REQ-020 CHECK: received byte equals running CRC -> shadow buffer copied to rev_data*, pack_done=1, frame_cnt+1, return to IDLE; else crc_err=1, err_cnt+1 (saturating), rev_data* unchanged, return to IDLE.
REQ-021 Latency: rev_data* update and pack_done occur on the first sys_clk edge after the cycle in which uart_done carries the CRC byte.
REQ-022 rev_data* change only together with pack_done; a partially received frame never alters them.
REQ-023 Gap counter clears on every uart_done and in IDLE; in PAYLOAD/CHECK, reaching _TIMEOUT_CYC with no byte -> timeout_err=1, err_cnt+1, return to IDLE.
REQ-024 uart_done and timeout in the same cycle: the byte wins, no timeout_err.
REQ-025 crc_err, timeout_err and pack_done are mutually exclusive and each lasts exactly one cycle.
REQ-026 Back-to-back frames with zero gap after the CRC byte are accepted: a header on the next uart_done after return to IDLE starts a new frame.

Reset
REQ-027 On sys_rst=1 at a sys_clk edge: state IDLE; rev_data*, frame_cnt, err_cnt, index, CRC, gap counter = 0; pack_done, crc_err, timeout_err, busy = 0.
REQ-028 Reset mid-frame discards the shadow buffer without any error pulse or counter change.

Structure
REQ-029 Shared package holds _HEADER, CRC-8 polynomial/init constants, state encodings and a byte-wise CRC-8 update function.
REQ-030 One sub-module, crc8_byte: combinational next-CRC from current CRC and data byte; there is no other hierarchy.

Verification
REQ-031 Header A5, payload 01..0B, correct CRC -> one pack_done one cycle after the CRC strobe, rev_data0=01 ... rev_data10=0B, frame_cnt=1.
REQ-032 Same frame with CRC byte XOR 0x01 -> crc_err pulse, rev_data* hold previous values, err_cnt=1, no pack_done.
REQ-033 Header plus 5 payload bytes, then silence for 50000 cycles -> timeout_err exactly at the gap limit, busy falls, err_cnt+1; the next full valid frame is accepted.
REQ-034 Garbage bytes 00,FF,3C before the header, and payload containing A5 -> the frame is accepted with A5 stored as data.
REQ-035 Assert sys_rst after 6 payload bytes, then send a full valid frame -> no error pulses, counters 0 then frame_cnt=1.
REQ-036 256 valid back-to-back frames -> frame_cnt wraps to 0; 300 bad-CRC frames -> err_cnt=255.
